// File: rtl/r_ptr_empty.sv
// Read-side pointer and empty flag for the async FIFO. It synchronises the Gray write pointer into rclk and keeps the binary and Gray read pointers.
// Latency: a write-pointer change shows in empty, rd_count and almost_empty SYNC_STAGES edges after it is sampled. A pop updates the flags on its own edge.
// Backpressure: a pop happens only when rinc=1 and the FIFO is not empty. A read attempted while empty is dropped and flagged on underflow.
module r_ptr_empty #(
    parameter int ADDR_W        = 5,
    parameter int SYNC_STAGES   = 2,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic              rclk,
    input  logic              rrst,
    input  logic              rinc,
    input  logic [ADDR_W:0]   g_wptr,
    output logic [ADDR_W-1:0] raddr,
    output logic [ADDR_W:0]   b_rptr,
    output logic [ADDR_W:0]   g_rptr,
    output logic              empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   rd_count,
    output logic              underflow
);

    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0] AE_THRESH = PW'(AEMPTY_THRESH);

    // Fewer than two stages gives no metastability protection.
    // More than four stages only adds latency.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("r_ptr_empty: SYNC_STAGES must be in 2..4");
    end

    // Synchroniser chain. The Gray code passes through undecoded, so at most one bit is ever in flight.
    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] sync_d [SYNC_STAGES];

    logic [PW-1:0] b_rptr_q,       b_rptr_d;
    logic [PW-1:0] g_rptr_q,       g_rptr_d;
    logic          empty_q,        empty_d;
    logic          almost_empty_q, almost_empty_d;
    logic [PW-1:0] rd_count_q,     rd_count_d;
    logic          underflow_q,    underflow_d;

    logic [PW-1:0] g_wptr_s;
    logic [PW-1:0] b_wptr_s;
    logic          pop;

    // Shift the raw write pointer one stage deeper each edge.
    always_comb begin
        sync_d[0] = g_wptr;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign g_wptr_s = sync_q[SYNC_STAGES-1];

    // Gray-to-binary conversion: each binary bit is the XOR of that Gray bit and all bits above it.
    always_comb begin
        b_wptr_s = '0;
        for (int i = 0; i < PW; i++) begin
            b_wptr_s[i] = ^(g_wptr_s >> i);
        end
    end

    // Next read pointer and flags, computed from the post-pop pointer so that draining the last word asserts empty with no bubble.
    always_comb begin
        pop            = rinc & ~empty_q;
        b_rptr_d       = b_rptr_q + {{ADDR_W{1'b0}}, pop};
        g_rptr_d       = b_rptr_d ^ (b_rptr_d >> 1);
        empty_d        = (g_rptr_d == g_wptr_s);
        rd_count_d     = b_wptr_s - b_rptr_d;
        almost_empty_d = (rd_count_d <= AE_THRESH);
        underflow_d    = rinc & empty_q;
    end

    // All read-domain state. A synchronous reset returns to the agreed empty state and discards any pop in the same cycle.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            b_rptr_q       <= '0;
            g_rptr_q       <= '0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            rd_count_q     <= '0;
            underflow_q    <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            b_rptr_q       <= b_rptr_d;
            g_rptr_q       <= g_rptr_d;
            empty_q        <= empty_d;
            almost_empty_q <= almost_empty_d;
            rd_count_q     <= rd_count_d;
            underflow_q    <= underflow_d;
        end
    end

    // g_rptr crosses to the write domain straight from a flop, so it cannot glitch.
    assign raddr        = b_rptr_q[ADDR_W-1:0];
    assign b_rptr       = b_rptr_q;
    assign g_rptr       = g_rptr_q;
    assign empty        = empty_q;
    assign almost_empty = almost_empty_q;
    assign rd_count     = rd_count_q;
    assign underflow    = underflow_q;

endmodule
